// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-row-at-a-time drive, 2-flop column sync,
// whole-scan debounce with ghost/multi-key rejection, single-cycle keydown events.
module keypad_scanner #(
   parameter int SCAN_DIV       = 5000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_col_n,
   output logic [3:0] o_row_n,
   output logic       o_keydown,
   output logic [3:0] o_key_id,
   output logic       o_key_held
);

   localparam int             DW         = $clog2(SCAN_DIV);
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]     DEB        = 4'(DEBOUNCE_SCANS);
   // Candidate encoding: bit 4 set means "no single key" (NONE), else bits 3:0 are the id.
   localparam logic [4:0]     NONE       = 5'b1_0000;

   logic [3:0]    r_col_meta;
   logic [3:0]    r_col_sync;
   logic [3:0]    r_row_n;
   logic [1:0]    r_row;
   logic [DW-1:0] r_dwell;
   logic [15:0]   r_samples;
   logic [4:0]    r_prev_cand;
   logic [4:0]    r_stable;
   logic [3:0]    r_match_cnt;
   logic          r_keydown;
   logic [3:0]    r_key_id;
   logic          r_key_held;

   logic          w_sample;
   logic          w_scan_end;
   logic [15:0]   w_scan;
   logic [4:0]    w_cand;
   logic [3:0]    w_next_cnt;
   logic          w_accept;

   assign w_sample   = (r_dwell == DWELL_LAST);
   assign w_scan_end = w_sample && (r_row == 2'd3);
   // Row 3 is still being sampled on the evaluating cycle, so splice it in directly.
   assign w_scan     = {~r_col_sync, r_samples[11:0]};

   always_comb begin
      w_cand = NONE;
      if ((w_scan != 16'h0000) && ((w_scan & (w_scan - 16'd1)) == 16'h0000)) begin
         for (int i = 0; i < 16; i++) begin
            if (w_scan[i]) w_cand = {1'b0, 4'(i)};
         end
      end
   end

   always_comb begin
      w_next_cnt = 4'd1;
      if (w_cand == r_prev_cand) begin
         w_next_cnt = (r_match_cnt >= DEB) ? DEB : (r_match_cnt + 4'd1);
      end
   end

   assign w_accept = (w_next_cnt == DEB) && (w_cand != r_stable);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col_meta <= 4'b1111;
         r_col_sync <= 4'b1111;
      end else begin
         r_col_meta <= i_col_n;
         r_col_sync <= r_col_meta;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dwell   <= '0;
         r_row     <= 2'd0;
         r_row_n   <= 4'b1110;
         r_samples <= 16'h0000;
      end else if (w_sample) begin
         r_dwell                    <= '0;
         r_row                      <= r_row + 2'd1;
         r_row_n                    <= {r_row_n[2:0], r_row_n[3]};
         r_samples[{r_row, 2'b00} +: 4] <= ~r_col_sync;
      end else begin
         r_dwell <= r_dwell + DW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_cand <= NONE;
         r_stable    <= NONE;
         r_match_cnt <= 4'd0;
         r_keydown   <= 1'b0;
         r_key_id    <= 4'd0;
         r_key_held  <= 1'b0;
      end else begin
         r_keydown <= 1'b0;
         if (w_scan_end) begin
            r_prev_cand <= w_cand;
            r_match_cnt <= w_next_cnt;
            if (w_accept) begin
               r_stable <= w_cand;
               if (w_cand[4]) begin
                  r_key_held <= 1'b0;
               end else begin
                  r_keydown  <= 1'b1;
                  r_key_id   <= w_cand[3:0];
                  r_key_held <= 1'b1;
               end
            end
         end
      end
   end

   assign o_row_n    = r_row_n;
   assign o_keydown  = r_keydown;
   assign o_key_id   = r_key_id;
   assign o_key_held = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model drives columns from pressed-key set,
// a per-scan reference model predicts keydown/key_id/key_held every cycle.
module tb_keypad_scanner;

   localparam int SD   = 4;
   localparam int DB   = 3;
   localparam int SCAN = 4 * SD;
   localparam int NONE = 16;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        keydown;
   logic [3:0]  key_id;
   logic        key_held;
   logic [15:0] keys  = 16'h0000;

   always #5 clk = ~clk;

   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         if (row_n[r] == 1'b0) begin
            for (int c = 0; c < 4; c++) begin
               if (keys[4*r+c]) col_n[c] = 1'b0;
            end
         end
      end
   end

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_col_n    (col_n),
      .o_row_n    (row_n),
      .o_keydown  (keydown),
      .o_key_id   (key_id),
      .o_key_held (key_held)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model state
   int          t;
   logic [15:0] hist [4];
   logic [15:0] samp;
   int          m_prev, m_cnt, m_stable, m_row, m_cand;
   logic        exp_kd   = 1'b0;
   logic        exp_held = 1'b0;
   logic [3:0]  exp_id   = 4'd0;
   int          m_kd     = 0;

   // Columns reach the sampling flop two cycles late, so row r is judged on the
   // key set present two cycles before its sample edge.
   initial begin
      t = 0; samp = '0; m_prev = NONE; m_cnt = 0; m_stable = NONE;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            t = 0; samp = '0; m_prev = NONE; m_cnt = 0; m_stable = NONE;
            exp_kd = 1'b0; exp_held = 1'b0; exp_id = 4'd0;
         end else begin
            exp_kd = 1'b0;
            hist[t % 4] = keys;
            if (t % 4 == 3) begin
               m_row = (t / 4) % 4;
               samp[4*m_row +: 4] = hist[(t - 2) % 4][4*m_row +: 4];
               if (m_row == 3) begin
                  m_cand = NONE;
                  if ($countones(samp) == 1) begin
                     for (int i = 0; i < 16; i++) if (samp[i]) m_cand = i;
                  end
                  if (m_cand == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
                  else m_cnt = 1;
                  m_prev = m_cand;
                  if (m_cnt == DB && m_cand != m_stable) begin
                     m_stable = m_cand;
                     if (m_cand != NONE) begin
                        exp_kd = 1'b1; exp_held = 1'b1; exp_id = 4'(m_cand); m_kd++;
                     end else begin
                        exp_held = 1'b0;
                     end
                  end
               end
            end
            t++;
         end
      end
   end

   bit         chk_en  = 1'b0;
   bit         prev_kd = 1'b0;
   int         kd_cnt  = 0;
   logic [3:0] last_id = 4'd0;
   logic [3:0] exp_row;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            exp_row = ~(4'b0001 << ((t / 4) % 4));
            chk("row_n", 32'(row_n), 32'(exp_row));
            chk("outs", 32'({keydown, key_held, key_id}), 32'({exp_kd, exp_held, exp_id}));
            chk("kd_consec", 32'(keydown & prev_kd), 32'd0);
            if (keydown) begin
               kd_cnt++;
               last_id = key_id;
            end
            prev_kd = keydown;
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   int mode, k1, k2;

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      #1;
      chk("rst_row_n", 32'(row_n), 32'hE);
      chk("rst_keydown", 32'(keydown), 32'd0);
      chk("rst_key_id", 32'(key_id), 32'd0);
      chk("rst_key_held", 32'(key_held), 32'd0);
      wait_cyc(4);
      rst_n = 1'b1;

      // clean press of id 13
      wait_cyc(2 * SCAN);
      kd_cnt = 0;
      wait_cyc($urandom_range(0, 15));
      keys[13] = 1'b1;
      wait_cyc(4 * SCAN + 3);
      chk("press13_cnt", 32'(kd_cnt), 32'd1);
      chk("press13_id", 32'(key_id), 32'd13);
      chk("press13_held", 32'(key_held), 32'd1);
      wait_cyc(6 * SCAN);
      chk("hold13_cnt", 32'(kd_cnt), 32'd1);

      // release and re-press
      kd_cnt = 0;
      keys = 16'h0000;
      wait_cyc(2 * SCAN);
      chk("release_early_held", 32'(key_held), 32'd1);
      wait_cyc(3 * SCAN);
      chk("release_held", 32'(key_held), 32'd0);
      chk("release_cnt", 32'(kd_cnt), 32'd0);
      chk("release_id", 32'(key_id), 32'd13);
      keys[13] = 1'b1;
      wait_cyc(5 * SCAN);
      chk("repress_cnt", 32'(kd_cnt), 32'd1);
      chk("repress_id", 32'(key_id), 32'd13);
      keys = 16'h0000;
      wait_cyc(5 * SCAN);

      // bounce on id 5
      kd_cnt = 0;
      m_kd   = 0;
      for (int i = 0; i < 8; i++) begin
         keys[5] = ~keys[5];
         wait_cyc(10);
      end
      keys[5] = 1'b1;
      wait_cyc(6 * SCAN);
      chk("bounce_cnt", 32'(kd_cnt), 32'(m_kd));
      chk("bounce_id", 32'(last_id), 32'd5);
      chk("bounce_held", 32'(key_held), 32'd1);
      keys = 16'h0000;
      wait_cyc(5 * SCAN);

      // multi-key 5+6, then keep 5
      kd_cnt = 0;
      keys = 16'h0060;
      wait_cyc(8 * SCAN);
      chk("multi_cnt", 32'(kd_cnt), 32'd0);
      chk("multi_held", 32'(key_held), 32'd0);
      keys[6] = 1'b0;
      wait_cyc(5 * SCAN);
      chk("multi_single_cnt", 32'(kd_cnt), 32'd1);
      chk("multi_single_id", 32'(key_id), 32'd5);
      keys = 16'h0000;
      wait_cyc(5 * SCAN);

      // direct switch 0 -> 10
      keys = 16'h0001;
      wait_cyc(5 * SCAN);
      chk("hold0_id", 32'(key_id), 32'd0);
      chk("hold0_held", 32'(key_held), 32'd1);
      kd_cnt = 0;
      keys = 16'h0400;
      wait_cyc(5 * SCAN);
      chk("switch_cnt", 32'(kd_cnt), 32'd1);
      chk("switch_id", 32'(key_id), 32'd10);
      chk("switch_held", 32'(key_held), 32'd1);

      // reset while holding id 10
      rst_n = 1'b0;
      #1;
      chk("midrst_row_n", 32'(row_n), 32'hE);
      chk("midrst_keydown", 32'(keydown), 32'd0);
      chk("midrst_key_id", 32'(key_id), 32'd0);
      chk("midrst_key_held", 32'(key_held), 32'd0);
      wait_cyc(3);
      rst_n = 1'b1;
      kd_cnt = 0;
      wait_cyc(4 * SCAN);
      chk("post_rst_cnt", 32'(kd_cnt), 32'd1);
      chk("post_rst_id", 32'(key_id), 32'd10);
      chk("post_rst_held", 32'(key_held), 32'd1);

      // randomized key patterns
      kd_cnt = 0;
      m_kd   = 0;
      for (int i = 0; i < 10; i++) begin
         mode = $urandom_range(0, 3);
         k1   = $urandom_range(0, 15);
         k2   = $urandom_range(0, 15);
         keys = 16'h0000;
         if (mode != 0) keys[k1] = 1'b1;
         if (mode == 2) keys[k2] = 1'b1;
         wait_cyc($urandom_range(1, 6) * SCAN + $urandom_range(0, 15));
      end
      keys = 16'h0000;
      wait_cyc(5 * SCAN);
      chk("rand_cnt", 32'(kd_cnt), 32'(m_kd));
      chk("rand_held", 32'(key_held), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the 4x4 matrix keypad and produces the debounced `keydown`/`key_id` event stream consumed by the keypad adapter.
- Scans rows one at a time, samples columns, and rejects ghosting and multi-key presses.
- Debounces over whole scans.
- Emits a single-cycle `keydown` per new stable key, with `key_id` = 4*row + col.

## Interface
- `SCAN_DIV`, 5000: cycles each row is driven before its columns are sampled; must be >= 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full-scan results needed to accept a change; range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row_n`  out  4  row drive, active-low, exactly one bit low at all times.
- `col_n`  in  4  column sense, active-low (board pull-ups), asynchronous to `clk`.
- `keydown`  out  1  one-cycle pulse: a new stable key was accepted.
- `key_id`  out  4  id of last accepted key, {row[1:0], col[1:0]}.
- `key_held`  out  1  high while the accepted key remains stably pressed.

## Operation
- **Column synchronization:** `col_n` passes through a 2-flop synchronizer before any use.
- **Row scan:**
  - Row counter r = 0..3 drives `row_n` = ~(1<<r).
  - Dwell counter runs 0..SCAN_DIV-1.
  - On dwell = SCAN_DIV-1, the synchronized columns are sampled for row r, then r advances, wrapping 3->0.
- **Scan result:**
  - At the row-3 sample, the 16 samples collected in that scan are evaluated.
  - Exactly one pressed bit gives candidate = its id.
  - Zero or >=2 pressed bits give candidate = NONE. Multi-key and ghost presses are never reported.
- **Debounce:**
  - `match_cnt` tracks consecutive equal candidates.
  - If candidate == previous candidate, it increments, saturating at DEBOUNCE_SCANS. Otherwise it is set to 1.
- **Acceptance:**
  - When `match_cnt` == DEBOUNCE_SCANS and candidate != `stable`, `stable` <= candidate.
  - If the new `stable` is a key K:
    - pulse `keydown`;
    - `key_id` <= K;
    - `key_held` <= 1.
  - If the new `stable` is NONE:
    - `key_held` <= 0;
    - no pulse;
    - `key_id` holds its last value.
- **Direct key change:** a direct stable change K->L (no accepted NONE between them) emits a `keydown` with `key_id` = L.
- **Holding a key:** no repeated `keydown` while `stable` is unchanged; there is no auto-repeat.

## Timing
- **Reset values** (asynchronous on `rst_n` low):
  - `row_n` = 4'b1110;
  - `keydown` = 0, `key_id` = 0, `key_held` = 0;
  - `stable` = NONE, previous candidate = NONE;
  - `match_cnt` = 0, dwell = 0, synchronizer flops = 4'b1111.
- **Reset mid-operation:** reset mid-scan or mid-hold abandons all state. A key still pressed after release is re-debounced and reported with a fresh `keydown`.
- **Scan period:** 4*SCAN_DIV cycles. The first scan completes at cycle 4*SCAN_DIV-1 after reset release.
- **Output registration:**
  - `keydown`, `key_id` and `key_held` are registered.
  - They update in the cycle after the evaluating row-3 sample.
  - `key_id` is valid in the same cycle as `keydown` and stays constant until the next `keydown`.
- **Press latency:** a key held steadily from before scan n begins is accepted after scan n+DEBOUNCE_SCANS-1.
  - The worst case from contact settle is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles, including the synchronizer.
- **Release latency:** DEBOUNCE_SCANS full NONE scans.
- **Bounce filtering:** any candidate change restarts the count, so bouncing shorter than one scan per state never produces a pulse.
- **Output rules:**
  - `keydown` is never high on two consecutive cycles.
  - `row_n` never has zero or more than one low bit.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan). The bench models the matrix: `col_n`[c] = 0 iff the driven row has key (r,c) closed.
- **Reset:** hold `rst_n`=0 for 5 cycles, then release.
  - During reset: `row_n`=1110, `keydown`=0, `key_id`=0, `key_held`=0.
  - After release: `row_n` steps 1110,1101,1011,0111 every 4 cycles, repeating.
- **Clean press of id 13 (row 3, col 1), held for 10 scans:**
  - Exactly one `keydown` pulse, with `key_id`=13 and `key_held`=1, within 4 scans + 3 cycles of press.
  - No further pulses while held.
- **Release of id 13:**
  - `key_held` falls after 3 NONE scans, with no pulse and `key_id` still 13.
  - A re-press yields a new single `keydown` with `key_id`=13.
- **Bounce:** toggle id 5 every 10 cycles for 80 cycles, then hold → exactly one `keydown`, with `key_id`=5.
- **Multi-key:** press ids 5 and 6 together for 8 scans, then release 6 while keeping 5.
  - No `keydown` while both are pressed.
  - Then exactly one `keydown` with `key_id`=5.
- **Direct switch and mid-hold reset:**
  - Switch from stably held id 0 directly to id 10 → one `keydown` with `key_id`=10.
  - Pulse `rst_n` low while `key_held`=1 → outputs return to reset values immediately. Id 10 is still pressed, so one new `keydown` with `key_id`=10 follows after 3 scans.
